hamming_fsk_pcm_top: RTL and testbench

//  Self-contained PCM loopback link: an internal 8-bit ramp source is split into nibbles,

---
 rtl/hamming_fsk_pcm_top.sv | 144 ++++++++++++++
 tb/tb_hamming_fsk_pcm_top.sv | 106 ++++++++++
 2 files changed

// File: rtl/hamming_fsk_pcm_top.sv
// Purpose: PCM loopback: ramp source -> Hamming(7,4) -> FSK mod -> FSK demod -> SEC decode -> PCMout.
// Latency: frame n word appears on PCMout 113 clocks after that frame starts (default params).
// Backpressure: none; free-running link with shared bit/frame timing, no handshakes.
module hamming_fsk_pcm_top #(
  parameter int         BIT_CYCLES = 8,
  parameter int         F0_HALF    = 4,
  parameter int         F1_HALF    = 2,
  parameter logic [7:0] SRC_STEP   = 8'd1,
  parameter int         ERR_INJECT = 0,
  parameter int         ERR_POS    = 3
) (
  input  logic       clk,
  input  logic       reset,
  output logic [7:0] PCMout
);

  localparam int            CW       = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BIT_CYCLES - 1);
  localparam logic [3:0]    BIT_LAST = 4'd13;

  // Codeword packed with position 1 in the MSB so it is sent first.
  function automatic logic [6:0] ham_enc(input logic [3:0] n);
    logic d1, d2, d3, d4;
    d1 = n[3]; d2 = n[2]; d3 = n[1]; d4 = n[0];
    return {d1 ^ d2 ^ d4, d1 ^ d3 ^ d4, d1, d2 ^ d3 ^ d4, d2, d3, d4};
  endfunction

  // Position p lives at bit index 7-p; a nonzero syndrome names the bad position.
  function automatic logic [3:0] ham_dec(input logic [6:0] cw);
    logic [6:0] c;
    logic [2:0] s;
    c    = cw;
    s[0] = c[6] ^ c[4] ^ c[2] ^ c[0];
    s[1] = c[5] ^ c[4] ^ c[1] ^ c[0];
    s[2] = c[3] ^ c[2] ^ c[1] ^ c[0];
    if (s != 3'd0) c[3'd7 - s] = ~c[3'd7 - s];
    return {c[4], c[2], c[1], c[0]};
  endfunction

  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    bit_q, bit_d;
  logic [7:0]    sample_q, sample_d;
  logic [7:0]    phase_q, phase_d;
  logic          fsk_q, fsk_d;
  logic          prev_q, prev_d;
  logic [CW:0]   tog_q, tog_d;
  logic [13:0]   rx_q, rx_d;
  logic          last_q, last_d;
  logic          done_q, done_d;
  logic [7:0]    pcm_q, pcm_d;

  logic [13:0] tx_word;
  logic        tx_bit;
  logic [7:0]  half;
  logic        win_end;
  logic [3:0]  pos;
  logic        inj;
  logic        line_in;

  // Next-state for timing, source, modulator, demodulator and reassembly.
  always_comb begin
    tx_word  = {ham_enc(sample_q[7:4]), ham_enc(sample_q[3:0])};
    tx_bit   = tx_word[BIT_LAST - bit_q];
    half     = tx_bit ? 8'(F1_HALF) : 8'(F0_HALF);
    win_end  = (cnt_q == CNT_LAST);
    pos      = (bit_q < 4'd7) ? 4'(bit_q + 4'd1) : 4'(bit_q - 4'd6);
    inj      = (ERR_INJECT != 0) && (pos == 4'(ERR_POS));
    line_in  = fsk_q ^ inj;

    cnt_d    = win_end ? '0 : CW'(cnt_q + 1'b1);
    bit_d    = bit_q;
    sample_d = sample_q;
    phase_d  = phase_q;
    fsk_d    = fsk_q;
    prev_d   = line_in;
    tog_d    = tog_q;
    rx_d     = rx_q;
    last_d   = win_end && (bit_q == BIT_LAST);
    done_d   = last_q;
    pcm_d    = pcm_q;

    if (win_end) begin
      if (bit_q == BIT_LAST) begin
        bit_d    = 4'd0;
        sample_d = sample_q + SRC_STEP;
      end else begin
        bit_d = bit_q + 4'd1;
      end
    end

    // Tone restarts from phase 0, line low, at every bit window.
    if (win_end) begin
      phase_d = 8'd0;
      fsk_d   = 1'b0;
    end else if (8'(phase_q + 8'd1) == half) begin
      phase_d = 8'd0;
      fsk_d   = ~fsk_q;
    end else begin
      phase_d = phase_q + 8'd1;
    end

    // Cycle 0 of a window is ignored; its edge instead commits the previous window's bit.
    if (cnt_q == '0) begin
      rx_d  = {rx_q[12:0], (tog_q >= (CW+1)'(2))};
      tog_d = '0;
    end else if (line_in != prev_q) begin
      tog_d = tog_q + 1'b1;
    end

    if (done_q) pcm_d = {ham_dec(rx_q[13:7]), ham_dec(rx_q[6:0])};
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q    <= '0;
      bit_q    <= '0;
      sample_q <= '0;
      phase_q  <= '0;
      fsk_q    <= 1'b0;
      prev_q   <= 1'b0;
      tog_q    <= '0;
      rx_q     <= '0;
      last_q   <= 1'b0;
      done_q   <= 1'b0;
      pcm_q    <= '0;
    end else begin
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      sample_q <= sample_d;
      phase_q  <= phase_d;
      fsk_q    <= fsk_d;
      prev_q   <= prev_d;
      tog_q    <= tog_d;
      rx_q     <= rx_d;
      last_q   <= last_d;
      done_q   <= done_d;
      pcm_q    <= pcm_d;
    end
  end

  assign PCMout = pcm_q;

endmodule

// File: tb/tb_hamming_fsk_pcm_top.sv
// Purpose: randomized reset-sequence bench for hamming_fsk_pcm_top against a frame-level model.
// Latency: model predicts PCMout and fsk line for every cycle after each edge.
// Backpressure: n/a; DUT has no flow control.
module tb_hamming_fsk_pcm_top;

  logic       clk;
  logic       reset;
  logic [7:0] pcm_def;
  logic [7:0] pcm_step;
  logic [7:0] pcm_err [1:7];

  int checks   = 0;
  int failures = 0;
  int k        = -1;  // index of last edge with reset high since release; -1 = in reset

  hamming_fsk_pcm_top u_dut_def (.clk(clk), .reset(reset), .PCMout(pcm_def));

  hamming_fsk_pcm_top #(.SRC_STEP(8'h55)) u_dut_step (.clk(clk), .reset(reset), .PCMout(pcm_step));

  for (genvar g = 1; g <= 7; g++) begin : g_err
    hamming_fsk_pcm_top #(.ERR_INJECT(1), .ERR_POS(g)) u_dut_err (
      .clk(clk), .reset(reset), .PCMout(pcm_err[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!reset) k <= -1;
    else        k <= k + 1;
  end

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s k=%0d got=0x%0h exp=0x%0h", tag, k, got, exp);
    end
  endtask

  // Frame-level view: frame n carries n*step and lands on PCMout at edge 112n+113.
  function automatic int exp_pcm(input int kk, input int step);
    if (kk < 113) return 0;
    return (((kk - 113) / 112) * step) % 256;
  endfunction

  // Hamming(7,4) bit at position 1..7 of the codeword for nibble nib.
  function automatic int enc_bit(input int nib, input int p);
    int d1, d2, d3, d4;
    d1 = (nib >> 3) & 1; d2 = (nib >> 2) & 1; d3 = (nib >> 1) & 1; d4 = nib & 1;
    case (p)
      1: return d1 ^ d2 ^ d4;
      2: return d1 ^ d3 ^ d4;
      3: return d1;
      4: return d2 ^ d3 ^ d4;
      5: return d2;
      6: return d3;
      default: return d4;
    endcase
  endfunction

  // Line level during frame-relative cycle j (state after edge j-1) for the default link.
  function automatic int exp_fsk(input int j);
    int fj, w, c, smp, nib, b;
    fj  = j % 112;
    w   = fj / 8;
    c   = j % 8;
    smp = (j / 112) % 256;
    nib = (w < 7) ? (smp >> 4) : (smp & 15);
    b   = enc_bit(nib, (w % 7) + 1);
    return (c / (b ? 2 : 4)) % 2;
  endfunction

  task automatic check_all();
    chk("pcm_def", int'(pcm_def), exp_pcm(k, 1));
    chk("pcm_step55", int'(pcm_step), exp_pcm(k, 'h55));
    for (int i = 1; i <= 7; i++) chk($sformatf("pcm_err%0d", i), int'(pcm_err[i]), exp_pcm(k, 1));
    chk("fsk_line", int'(u_dut_def.fsk_q), exp_fsk(k + 1));
  endtask

  task automatic run(input int n, input logic r);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_all();
      reset = r;
    end
  endtask

  initial begin
    reset = 1'b0;
    run(10, 1'b0);          // hold in reset
    run(150, 1'b1);         // released, abort mid-frame around cycle 150
    run(3, 1'b0);           // short reset
    run(600, 1'b1);         // five full frames after restart
    for (int r = 0; r < 3; r++) begin
      run($urandom_range(400, 50), 1'b0);
      run($urandom_range(5, 1), 1'b1);
    end
    run(1900, 1'b1);        // long run: 0x55 wrap and frame 15 (sample 0x0F)
    run(1, 1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
